// File: rtl/ram8_burst_ctrl_if.sv
// Command, write-data, read-data and RAM-side signals of the ram8 burst front-end.
// master: command source, data producer/consumer and RAM. slave: the controller.
interface ram8_burst_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic [2:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] mem_val;
    logic        mem_load;
    logic [2:0]  mem_address;
    logic [15:0] mem_out;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_val, mem_load, mem_address
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_out,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_val, mem_load, mem_address
    );
endinterface

// File: rtl/ram8_burst_ctrl.sv
// Read/write burst controller in front of the 8x16 synchronous RAM; read data goes through
// a 2-entry buffer so the RAM's 1-cycle latency is hidden under full backpressure.
module ram8_burst_ctrl (
    input  logic               clk,
    input  logic               rst,
    ram8_burst_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    state_e      r_state, w_state_nxt;
    logic [2:0]  r_addr, w_addr_nxt;
    logic [3:0]  r_rem, w_rem_nxt;
    logic        r_infl, w_infl_nxt;
    logic [1:0]  r_occ, w_occ_nxt;
    logic [15:0] r_buf0, w_buf0_nxt;
    logic [15:0] r_buf1, w_buf1_nxt;
    logic        r_done, w_done_nxt;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_beat;

    always_comb begin
        w_pop   = (r_occ != 2'd0) && bus.rd_ready;
        w_push  = r_infl;
        // Buffered words plus the one in flight, minus the one leaving, must stay below 2.
        w_issue = (r_state == StRead) &&
                  (({1'b0, r_occ} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop}));
        w_beat  = (r_state == StWrite) && bus.wr_valid;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        w_infl_nxt  = w_issue;
        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid) begin
                    w_addr_nxt  = bus.cmd_addr;
                    w_rem_nxt   = {1'b0, bus.cmd_len} + 4'd1;
                    w_state_nxt = bus.cmd_write ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (w_beat) begin
                    w_addr_nxt = r_addr + 3'd1;
                    w_rem_nxt  = r_rem - 4'd1;
                    if (r_rem == 4'd1) begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            StRead: begin
                if (w_issue) begin
                    w_addr_nxt = r_addr + 3'd1;
                    w_rem_nxt  = r_rem - 4'd1;
                    if (r_rem == 4'd1) w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                // Leave once the buffer will be empty after this cycle's pop.
                if (!r_infl && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_occ_nxt  = r_occ;
        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        case ({w_push, w_pop})
            2'b01: begin
                w_buf0_nxt = r_buf1;
                w_occ_nxt  = r_occ - 2'd1;
            end
            2'b10: begin
                if (r_occ == 2'd0) w_buf0_nxt = bus.mem_out;
                else               w_buf1_nxt = bus.mem_out;
                w_occ_nxt = r_occ + 2'd1;
            end
            2'b11: begin
                if (r_occ == 2'd1) begin
                    w_buf0_nxt = bus.mem_out;
                end else begin
                    w_buf0_nxt = r_buf1;
                    w_buf1_nxt = bus.mem_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_addr  <= 3'd0;
            r_rem   <= 4'd0;
            r_infl  <= 1'b0;
            r_occ   <= 2'd0;
            r_buf0  <= 16'd0;
            r_buf1  <= 16'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_rem   <= w_rem_nxt;
            r_infl  <= w_infl_nxt;
            r_occ   <= w_occ_nxt;
            r_buf0  <= w_buf0_nxt;
            r_buf1  <= w_buf1_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.cmd_ready   = (r_state == StIdle);
    assign bus.busy        = (r_state != StIdle);
    assign bus.done        = r_done;
    assign bus.wr_ready    = (r_state == StWrite);
    assign bus.rd_valid    = (r_occ != 2'd0);
    assign bus.rd_data     = r_buf0;
    assign bus.mem_load    = w_beat;
    assign bus.mem_address = r_addr;
    assign bus.mem_val     = (r_state == StWrite) ? bus.wr_data : 16'd0;
endmodule

// File: tb/tb_ram8_burst_ctrl.sv
// Directed bench for ram8_burst_ctrl with a behavioural RAM and a word-level scoreboard.
module tb_ram8_burst_ctrl;
    logic clk;
    logic rst;

    ram8_burst_ctrl_if bus ();

    ram8_burst_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram8: write at the edge, registered read of the old contents.
    logic [15:0] ram [8];
    always @(posedge clk) begin
        if (bus.mem_load) ram[bus.mem_address] <= bus.mem_val;
        bus.mem_out <= ram[bus.mem_address];
    end

    int          n_tests;
    int          n_fail;
    int          n_done;
    logic [15:0] sb_mem [8];
    logic [15:0] exp_rq [$];
    logic [18:0] exp_wq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Word-level compare: every popped read word and every RAM write beat against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_rq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_extra: got word %0h, expected none", bus.rd_data);
                end else begin
                    check("rd_word", bus.rd_data, exp_rq.pop_front());
                end
            end
            if (bus.mem_load) begin
                if (exp_wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_extra: got beat @%0h=%0h, expected none",
                             bus.mem_address, bus.mem_val);
                end else begin
                    check("wr_beat", {bus.mem_address, bus.mem_val}, exp_wq.pop_front());
                end
            end
            if (bus.done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_wr_ready"}, bus.wr_ready, 0);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_rd_data"}, bus.rd_data, 0);
        check({tag, "_mem_load"}, bus.mem_load, 0);
        check({tag, "_mem_address"}, bus.mem_address, 0);
        check({tag, "_mem_val"}, bus.mem_val, 0);
    endtask

    task automatic send_cmd(input logic w, input logic [2:0] a, input logic [2:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        #1;
        for (int i = 0; i < 40 && !bus.cmd_ready; i++) tick();
        check("cmd_ready_wait", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [2:0] len, input logic [15:0] base,
                            input bit toggle, input bit hold, input logic [2:0] ha,
                            input logic [2:0] hl, output int done_cyc);
        int L;
        int beats;
        int cyc;
        logic [2:0] wa;
        L = int'(len) + 1;
        for (int k = 0; k < L; k++) begin
            wa = a + 3'(k);
            sb_mem[wa] = base + 16'(k);
            exp_wq.push_back({wa, base + 16'(k)});
        end
        send_cmd(1'b1, a, len);
        if (hold) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b0;
            bus.cmd_addr  = ha;
            bus.cmd_len   = hl;
        end
        beats = 0;
        cyc   = 1;
        while (beats < L && cyc < 40) begin
            bus.wr_valid = toggle ? cyc[0] : 1'b1;
            bus.wr_data  = base + 16'(beats);
            #1;
            check("wr_load_mirror", bus.mem_load, bus.wr_valid);
            check("wr_cmd_blocked", bus.cmd_ready, 0);
            check("wr_busy", bus.busy, 1);
            tick();
            if (bus.wr_valid) beats++;
            cyc++;
        end
        bus.wr_valid = 1'b0;
        #1;
        check("wr_done_pulse", bus.done, 1);
        check("wr_idle_ready", bus.cmd_ready, 1);
        check("wr_all_beats", exp_wq.size(), 0);
        done_cyc = cyc;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [2:0] len, input int stall_end,
                           input int rst_cyc, output int first_cyc,
                           output logic [15:0] first_word, output int done_cyc);
        int L;
        int cyc;
        logic [2:0] ra;
        L = int'(len) + 1;
        for (int k = 0; k < L; k++) begin
            ra = a + 3'(k);
            exp_rq.push_back(sb_mem[ra]);
        end
        send_cmd(1'b0, a, len);
        cyc        = 1;
        first_cyc  = -1;
        first_word = 16'd0;
        done_cyc   = -1;
        while (done_cyc < 0 && cyc < 80) begin
            bus.rd_ready = (cyc > stall_end);
            #1;
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                chk_reset("midrst");
                exp_rq.delete();
                tick();
                rst = 1'b0;
                bus.rd_ready = 1'b1;
                return;
            end
            if (bus.rd_valid && first_cyc < 0) begin
                first_cyc  = cyc;
                first_word = bus.rd_data;
            end
            if (stall_end > 0 && cyc >= 3 && cyc <= stall_end) begin
                check("stall_valid", bus.rd_valid, 1);
                check("stall_hold", bus.rd_data, sb_mem[a]);
            end
            if (stall_end > 0 && cyc == stall_end) check("stall_two_issues", bus.mem_address,
                                                         a + 3'd2);
            if (bus.done) done_cyc = cyc;
            else tick();
            cyc++;
        end
        bus.rd_ready = 1'b1;
        check("rd_done_seen", done_cyc > 0, 1);
        check("rd_all_words", exp_rq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int fc;
        int nd0;
        logic [15:0] fw;
        n_tests = 0;
        n_fail  = 0;
        n_done  = 0;
        for (int i = 0; i < 8; i++) sb_mem[i] = 16'd0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 3'd0;
        bus.cmd_len   = 3'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 16'd0;
        bus.rd_ready  = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();
        chk_reset("post_rst");

        // Fill all eight words.
        do_write(3'd0, 3'd7, 16'h1000, 0, 0, 3'd0, 3'd0, dc);
        check("fill_done_cyc", dc, 9);

        // Wrapping write then read of 6,7,0,1.
        do_write(3'd6, 3'd3, 16'hA000, 0, 0, 3'd0, 3'd0, dc);
        check("wrap_wr_done_cyc", dc, 5);
        do_read(3'd6, 3'd3, 0, 0, fc, fw, dc);
        check("wrap_rd_first_cyc", fc, 3);
        check("wrap_rd_first_word", fw, 16'hA000);
        check("wrap_rd_done_cyc", dc, 7);

        // Eight-word read with rd_ready low for cycles 1..6.
        do_read(3'd0, 3'd7, 6, 0, fc, fw, dc);
        check("stall_first_word", fw, 16'hA002);

        // wr_valid toggling: 4 beats over 7 cycles.
        do_write(3'd2, 3'd3, 16'hC000, 1, 0, 3'd0, 3'd0, dc);
        check("toggle_done_cyc", dc, 8);
        do_read(3'd2, 3'd3, 0, 0, fc, fw, dc);
        check("toggle_rd_first_word", fw, 16'hC000);
        check("toggle_rd_done_cyc", dc, 7);

        // A read command held pending during a write burst.
        do_write(3'd5, 3'd1, 16'hB000, 0, 1, 3'd5, 3'd1, dc);
        check("hold_wr_done_cyc", dc, 3);
        do_read(3'd5, 3'd1, 0, 0, fc, fw, dc);
        check("hold_rd_first_cyc", fc, 3);
        check("hold_rd_first_word", fw, 16'hB000);
        check("hold_rd_done_cyc", dc, 5);

        // Reset in cycle 4 of an eight-word read, then a clean read.
        tick();
        nd0 = n_done;
        do_read(3'd1, 3'd7, 0, 4, fc, fw, dc);
        do_read(3'd3, 3'd2, 0, 0, fc, fw, dc);
        check("after_rst_first_word", fw, 16'hC001);
        check("after_rst_done_cyc", dc, 6);
        tick();
        check("after_rst_done_count", n_done - nd0, 1);

        // Single word at address 7.
        nd0 = n_done;
        do_write(3'd7, 3'd0, 16'h5A5A, 0, 0, 3'd0, 3'd0, dc);
        check("single_wr_done_cyc", dc, 2);
        do_read(3'd7, 3'd0, 0, 0, fc, fw, dc);
        check("single_rd_first_word", fw, 16'h5A5A);
        check("single_rd_done_cyc", dc, 4);
        tick();
        check("single_done_after", bus.done, 0);
        check("single_done_count", n_done - nd0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
